// File: rtl/sram_arb_multi_port.sv
// Multi-channel round-robin SRAM with byte enables, fixed read latency and zero-init sweep.
// Optional per-byte even parity storage/checking is enabled with `define SRAM_PARITY_EN.
module sram_arb_multi_port #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_CH-1:0]              req_re,
   input  logic [NUM_CH-1:0]              req_we,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_CH*DATA_WIDTH/8-1:0] req_be,
   output logic [NUM_CH-1:0]              req_gnt,
   output logic [NUM_CH-1:0]              resp_valid,
   output logic [DATA_WIDTH-1:0]          resp_rdata,
   output logic                           init_done
`ifdef SRAM_PARITY_EN
   ,
   output logic                           parity_err
`endif
);

   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
   logic                  init_done_q, init_done_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [NUM_CH-1:0]     req_any;
   logic                  found;
   int unsigned           sel, cand;
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [DATA_WIDTH-1:0] g_wdata;
   logic [NB-1:0]         g_be;
   logic                  g_we;
   logic                  init_we;

   assign req_any = req_re | req_we;
   assign init_we = reset_n && (state_q == ST_INIT);

   // Grants only in RUN and never while reset is being asserted.
   always_comb begin
      found   = 1'b0;
      sel     = 0;
      cand    = 0;
      req_gnt = '0;
      if (reset_n && (state_q == ST_RUN)) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_CH;
            if (!found && req_any[cand]) begin
               found = 1'b1;
               sel   = cand;
            end
         end
      end
      if (found) req_gnt[sel] = 1'b1;
   end

   assign g_addr  = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
   assign g_wdata = req_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
   assign g_be    = req_be[sel*NB +: NB];
   assign g_we    = req_we[sel];

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      init_done_d = init_done_q;
      rr_ptr_d    = found ? PW'((sel + 1) % NUM_CH) : rr_ptr_q;
      if (state_q == ST_INIT) begin
         init_addr_d = init_addr_q + 1'b1;
         if (init_addr_q == '1) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         init_done_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         init_done_q <= init_done_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign init_done = init_done_q;

   always_ff @(posedge clk) begin
      if (init_we) begin
         mem_q[init_addr_q] <= '0;
      end else if (found && g_we) begin
         for (int unsigned b = 0; b < NB; b++)
            if (g_be[b]) mem_q[g_addr][8*b +: 8] <= g_wdata[8*b +: 8];
      end
   end

`ifdef SRAM_PARITY_EN
   logic [NB-1:0] par_q [DEPTH];
   logic          rd_perr;

   always_ff @(posedge clk) begin
      if (init_we) begin
         par_q[init_addr_q] <= '0;
      end else if (found && g_we) begin
         for (int unsigned b = 0; b < NB; b++)
            if (g_be[b]) par_q[g_addr][b] <= ^g_wdata[8*b +: 8];
      end
   end

   always_comb begin
      rd_perr = 1'b0;
      for (int unsigned b = 0; b < NB; b++)
         if ((^mem_q[g_addr][8*b +: 8]) != par_q[g_addr][b]) rd_perr = 1'b1;
   end
`endif

   // Stage 0 captures the array at the grant edge; stage RD_LATENCY-1 drives the outputs.
   logic [NUM_CH-1:0]     pv_q [RD_LATENCY];
   logic                  pr_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];
   logic                  pe_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0] hold_q;
   logic                  last_rd;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            pv_q[i] <= '0;
            pr_q[i] <= 1'b0;
            pd_q[i] <= '0;
            pe_q[i] <= 1'b0;
         end
         hold_q <= '0;
      end else begin
         pv_q[0] <= req_gnt;
         pr_q[0] <= found && !g_we;
         pd_q[0] <= mem_q[g_addr];
`ifdef SRAM_PARITY_EN
         pe_q[0] <= rd_perr;
`else
         pe_q[0] <= 1'b0;
`endif
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pr_q[i] <= pr_q[i-1];
            pd_q[i] <= pd_q[i-1];
            pe_q[i] <= pe_q[i-1];
         end
         hold_q <= resp_rdata;
      end
   end

   assign last_rd    = pr_q[RD_LATENCY-1] && (|pv_q[RD_LATENCY-1]);
   assign resp_valid = pv_q[RD_LATENCY-1];
   assign resp_rdata = last_rd ? pd_q[RD_LATENCY-1] : hold_q;

`ifdef SRAM_PARITY_EN
   assign parity_err = last_rd && pe_q[RD_LATENCY-1];
`else
   logic unused_pe;
   assign unused_pe = pe_q[RD_LATENCY-1];
`endif

endmodule

// File: doc/sram_arb_multi_port.md
Name: sram_arb_multi_port

Overview:
- Parametrised successor to the single-port dummy SRAM.
- Serves NUM_CH independent requesters through one round-robin arbiter into a 2**ADDR_WIDTH-deep word array.
- Adds byte write enables, a pipelined fixed read latency, one access per cycle, and a hardware zero-init sweep after reset.
- Sits between the memory interface (mif) clients and the behavioural memory model.

Parameters:
- DATA_WIDTH, 16: word width; must be a multiple of 8.
- ADDR_WIDTH, 14: address width; depth is 2**ADDR_WIDTH.
- NUM_CH, 2: number of requester channels, 1..8.
- RD_LATENCY, 1: cycles from grant to resp_valid, 1..4.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- req_re  in  NUM_CH  per-channel read request.
- req_we  in  NUM_CH  per-channel write request.
- req_addr  in  NUM_CH*ADDR_WIDTH  channel c address at [c*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_CH*DATA_WIDTH  write data, packed the same way.
- req_be  in  NUM_CH*DATA_WIDTH/8  byte enables; bit 0 is the LSB byte.
- req_gnt  out  NUM_CH  one-hot grant pulse.
- resp_valid  out  NUM_CH  one-hot response pulse.
- resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid for reads.
- init_done  out  1  high once the zero sweep has finished.
- parity_err  out  1  present only with SRAM_PARITY_EN.

Behaviour:
- Clock and reset: single clock. reset_n is sampled on the rising edge of clk and is synchronous, active-low.
- Reset values: req_gnt=0, resp_valid=0, resp_rdata=0, init_done=0, parity_err=0, RR pointer=0. All pipeline stages are flushed.
- FSM states: INIT, RUN.
- INIT:
  - Entered on reset.
  - Writes 0 to address k on cycle k after reset release, for k = 0 .. 2**ADDR_WIDTH-1.
  - No grants are issued during INIT.
  - After the last address: init_done goes high on the next cycle, FSM moves to RUN.
- RUN: stays in RUN until the next reset.
- Request handshake:
  - A channel is requesting when req_re|req_we is high.
  - The requester holds addr, wdata and be stable until it sees req_gnt for its channel.
  - req_gnt is combinational from the current requests and the RR pointer, so a grant is possible in the same cycle.
  - If req_re and req_we are both high, the request is a write; re is ignored.
- Arbitration:
  - At most one grant per cycle. Search starts at the RR pointer and wraps modulo NUM_CH.
  - After a grant to channel c, the pointer becomes (c+1) mod NUM_CH.
  - With no grant, the pointer holds.
- Write:
  - Committed at the edge of the grant cycle.
  - Only bytes with be=1 are updated; be=0 on all bytes is a legal no-op write.
- Read:
  - Array is read at the grant-cycle edge, then delayed through RD_LATENCY-1 register stages.
  - A read issued the cycle after a write to the same address returns the new data (write-first).
- Response:
  - resp_valid[c] pulses exactly RD_LATENCY cycles after req_gnt[c], for both reads and writes.
  - resp_rdata holds its last read value otherwise; it is unchanged by write responses.
- Throughput: back-to-back grants each cycle; responses return in grant order.
- Address range: every ADDR_WIDTH-bit address is in range; no wrap logic.
- Reset mid-operation: in-flight responses are dropped (no resp_valid) and INIT restarts from address 0. Contents before INIT are undefined.
- Requests during INIT: held by the requester, no grant, no error.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte, computed on each written byte; INIT writes parity 0.
  - On read, the stored parity is checked per byte.
  - parity_err pulses together with resp_valid if any byte mismatches. resp_rdata is still delivered.
  - The bench hook is a hierarchical force on the parity array.
- Undefined: no parity storage or checking, and no parity_err port.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=4, NUM_CH=2, RD_LATENCY=2):
- Reset init: release reset_n -> no grants for 16 cycles, init_done high on cycle 16; read of each address 0..15 returns 16'h0000.
- Byte enables: ch0 writes addr 3 = 16'hA5C3 with be=2'b11, then addr 3 = 16'h00FF with be=2'b01; ch0 reads addr 3 -> resp_rdata 16'hA5FF, resp_valid[0] exactly 2 cycles after its gnt.
- Round-robin: both channels hold reads continuously -> grants alternate ch0, ch1, ch0, ch1 …; responses alternate in the same order with 2-cycle offset.
- Write/read both asserted: ch1 sets re=we=1 with addr 7, wdata 16'h1234 -> treated as a write; a later read of addr 7 = 16'h1234.
- Reset mid-flight: reset_n low one cycle after a read grant -> no resp_valid; INIT restarts; addr 3 reads 0 afterwards.
- Parity (SRAM_PARITY_EN): write 16'h0F0F, corrupt the high-byte parity bit, read -> parity_err=1 with resp_valid and resp_rdata 16'h0F0F.
